inv_sub_bytes_seq: RTL and testbench

- Iterative AES InvSubBytes engine.
- Applies the inverse S-box (the mapping that undoes the forward SubBytes S-box) to all 16 bytes of a 128-bit state.
- Processes LANES bytes per clock and uses a valid/ready handshake on both input and output.
- Sits on the decryption/key-check path, alongside the forward S-box datapath. It lets the core invert SubBytes without a second full-width 16-lookup combinational array.

---
 rtl/inv_sub_bytes_seq.sv | 130 +++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: inverse-substitutes a 128-bit state LANES
// bytes per cycle behind valid/ready handshakes on input and output.
module inv_sub_bytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned NBYTES   = 16;
    localparam int unsigned GROUPS   = NBYTES / LANES;
    localparam int unsigned CW       = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned LAST_GRP = GROUPS - 1;

    // Only power-of-two lane counts that evenly tile the 16-byte state are supported
    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Inverse AES S-box, indexed by the substituted byte value
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  grp, grp_n;
    logic [127:0]   work, work_n, work_sub;
    logic           out_valid_n;
    logic [127:0]   out_data_n;
    int unsigned    bidx;

    // Substitute the current group of LANES bytes; byte 0 sits in the top byte lane
    always_comb begin
        work_sub = work;
        bidx     = 0;
        for (int unsigned l = 0; l < LANES; l++) begin
            bidx = 32'(grp) * LANES + l;
            work_sub[8*(15-bidx) +: 8] = INV_SBOX[work[8*(15-bidx) +: 8]];
        end
    end

    // Next-state and next-value logic for the control FSM and datapath registers
    always_comb begin
        state_n     = state;
        grp_n       = grp;
        work_n      = work;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    work_n  = in_data;
                    grp_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                work_n = work_sub;
                grp_n  = grp + CW'(1);
                if (grp == CW'(LAST_GRP)) begin
                    grp_n       = '0;
                    out_valid_n = 1'b1;
                    out_data_n  = work_sub;
                    state_n     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; in_ready/busy are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grp       <= '0;
            work      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            grp       <= grp_n;
            work      <= work_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            in_ready  <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq; the reference inverse S-box is
// derived from GF(2^8) arithmetic rather than copied from a table.
module tb_inv_sub_bytes_seq;

    localparam int unsigned LANES  = 4;
    localparam int unsigned GROUPS = 16 / LANES;
    localparam int          NBLK   = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int npass  = 0;
    int ntotal = 0;

    logic [7:0] fwd_s [256];
    logic [7:0] inv_s [256];

    inv_sub_bytes_seq #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // Forward S-box = affine(multiplicative inverse); inverse S-box by inverting that map
    task automatic build_tables();
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
                end
            end
            fwd_s[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_s[fwd_s[x]] = 8'(x);
    endtask

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*(15-k) +: 8] = inv_s[d[8*(15-k) +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            step();
            lat++;
        end
    endtask

    // Accept one block with out_ready high and check latency, result and return to IDLE
    task automatic run_block(input string tag, input logic [127:0] d, input logic [127:0] exp);
        int lat;
        check({tag, "_in_ready_pre"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = rand128();
        check({tag, "_busy"}, 128'(busy), 128'd1);
        wait_valid(lat);
        check({tag, "_latency"}, 128'(lat), 128'(GROUPS));
        check({tag, "_data"}, out_data, exp);
        step();
        check({tag, "_out_valid_drop"}, 128'(out_valid), 128'd0);
        check({tag, "_in_ready_post"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        logic [127:0] d, held, fdat;
        logic [127:0] q[$];
        int lat, cyc, last_acc, got, sent;
        logic acc, hs;

        build_tables();

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        rst = 1'b0;

        // Directed known-answer blocks
        run_block("all63", {16{8'h63}}, 128'd0);
        run_block("kat_lo", 128'h637c777bf26b6fc53001672bfed7ab76,
                  128'h000102030405060708090a0b0c0d0e0f);
        for (int k = 0; k < 16; k++) fdat[8*(15-k) +: 8] = fwd_s[8'hf0 + k];
        run_block("kat_hi", fdat, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);

        // Backpressure: result held in DONE, stray in_valid ignored
        out_ready = 1'b0;
        d         = rand128();
        in_valid  = 1'b1;
        in_data   = d;
        step();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_latency", 128'(lat), 128'(GROUPS));
        held = out_data;
        check("bp_data", held, model(d));
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = rand128();
            step();
            check($sformatf("bp_valid_%0d", i), 128'(out_valid), 128'd1);
            check($sformatf("bp_hold_%0d", i), out_data, held);
            check($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", 128'(out_valid), 128'd0);
        check("bp_release_in_ready", 128'(in_ready), 128'd1);

        // Reset during the second BUSY cycle discards the block
        in_valid = 1'b1;
        in_data  = rand128();
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_out_data", out_data, 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_in_ready", 128'(in_ready), 128'd1);

        // Reset wins over a simultaneous in_valid
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = rand128();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        check("rst_vs_valid_busy", 128'(busy), 128'd0);
        check("rst_vs_valid_out_valid", 128'(out_valid), 128'd0);
        run_block("zeros", 128'd0, {16{8'h52}});

        // Back-to-back random blocks with both handshakes held open
        cyc      = 0;
        last_acc = -1;
        got      = 0;
        sent     = 0;
        in_valid = 1'b1;
        in_data  = rand128();
        while (got < NBLK && cyc < 20000) begin
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                if (q.size() == 0) check("bb_spurious_out", 128'(q.size()), 128'd1);
                else check($sformatf("bb_data_%0d", got), out_data, q.pop_front());
                got++;
            end
            if (acc) begin
                q.push_back(model(in_data));
                if (last_acc >= 0)
                    check($sformatf("bb_spacing_%0d", sent), 128'(cyc - last_acc), 128'(GROUPS + 2));
                last_acc = cyc;
                sent++;
            end
            step();
            cyc++;
            if (acc) begin
                if (sent == NBLK) in_valid = 1'b0;
                else in_data = rand128();
            end
        end
        check("bb_block_count", 128'(got), 128'(NBLK));

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
